// File: rtl/poc_pkg.sv
// Shared definitions for the parallel-output-controller (POC) subsystem.
// Holds the CPU and POC state encodings, the status-register bit index of
// the POC ready flag, and the default printer busy time.
package poc_pkg;

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_POLL,
        CPU_WAIT_IRQ,
        CPU_WRITE
    } cpu_state_t;

    typedef enum logic [1:0] {
        POC_READY,
        POC_SEND,
        POC_WAIT_PRN
    } poc_state_t;

    // Bit of the status register that flags "POC ready for a new byte".
    localparam int SR_READY = 7;

    // Printer busy time in clock cycles after each strobe (1..255).
    localparam int DEFAULT_PRINT_DELAY = 8;

endpackage

// File: rtl/poc_if.sv
// Request/result bundle of the POC subsystem.
//   func        print request (rising edge is the request)
//   data_input  byte to print, captured on the request edge
//   Switch      transfer mode: 0 = polling, 1 = interrupt
//   data        last byte accepted by the printer model
// With POC_STATUS_EN defined the bundle also carries:
//   ready       POC ready flag (status bit SR7)
//   irq         interrupt request towards the CPU model
// master: the requester side; slave: the poc_top side.
interface poc_if;

    logic       func;
    logic [7:0] data_input;
    logic       Switch;
    logic [7:0] data;
`ifdef POC_STATUS_EN
    logic       ready;
    logic       irq;

    modport master (output func, data_input, Switch, input data, ready, irq);
    modport slave  (input func, data_input, Switch, output data, ready, irq);
`else
    modport master (output func, data_input, Switch, input data);
    modport slave  (input func, data_input, Switch, output data);
`endif

endinterface

// File: rtl/poc_printer.sv
// Printer model. Accepts a byte on a strobe while idle, shows it on data
// and stays busy (rdy low) for PRINT_DELAY cycles.
//   CLK, RST  clock and synchronous active-high reset
//   tr        strobe from the POC
//   pd        byte presented with the strobe
//   rdy       printer idle
//   data      last accepted byte
module poc_printer
    import poc_pkg::*;
#(
    parameter int PRINT_DELAY = DEFAULT_PRINT_DELAY
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tr,
    input  logic [7:0] pd,
    output logic       rdy,
    output logic [7:0] data
);

    logic       rdy_reg;
    logic [7:0] data_reg;
    logic [7:0] count_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdy_reg   <= 1'b1;
            data_reg  <= 8'h00;
            count_reg <= 8'h00;
        end else if (tr && rdy_reg) begin
            data_reg  <= pd;
            rdy_reg   <= 1'b0;
            count_reg <= 8'(PRINT_DELAY);
        end else if (count_reg != 8'h00) begin
            count_reg <= count_reg - 8'd1;
            // Becomes ready on the same edge the count reaches zero.
            if (count_reg == 8'd1) begin
                rdy_reg <= 1'b1;
            end
        end
    end

    assign rdy  = rdy_reg;
    assign data = data_reg;

endmodule

// File: rtl/poc_top.sv
// POC subsystem top: CPU-side request model, POC register/handshake block
// and printer model. A rising edge on func requests printing of
// data_input; the CPU model hands the byte to the POC by polling SR7
// (Switch=0) or by waiting for irq (Switch=1); the POC strobes it to the
// printer, whose accepted byte appears on data five edges after the
// request edge when the printer is idle.
//   CLK, RST  clock and synchronous active-high reset
//   bus       poc_if.slave: func, data_input, Switch in; data out
// Optional macro POC_STATUS_EN adds bus.ready (SR7) and bus.irq outputs.
module poc_top
    import poc_pkg::*;
#(
    parameter int PRINT_DELAY = DEFAULT_PRINT_DELAY
) (
    input  logic  CLK,
    input  logic  RST,
    poc_if.slave  bus
);

    cpu_state_t cpu_state_reg, cpu_state_next;
    poc_state_t poc_state_reg, poc_state_next;

    logic                   func_q_reg;
    logic                   pending_reg;
    logic [7:0]             req_data_reg;
    logic                   mode_irq_reg;
    logic [7:0]             br_reg;
    logic [SR_READY:SR_READY] sr_reg;
    logic                   tr_reg;
    logic [7:0]             pd_reg;

    logic req_edge;
    logic irq;
    logic dispatch;
    logic write_en;
    logic send;
    logic done;
    logic prn_rdy;
    logic [7:0] prn_data;

    assign req_edge = bus.func & ~func_q_reg;
    assign irq      = sr_reg[SR_READY] & mode_irq_reg;

    // CPU request model
    always_comb begin
        cpu_state_next = cpu_state_reg;
        dispatch       = 1'b0;
        write_en       = 1'b0;
        case (cpu_state_reg)
            CPU_IDLE: begin
                if (pending_reg) begin
                    dispatch       = 1'b1;
                    cpu_state_next = bus.Switch ? CPU_WAIT_IRQ : CPU_POLL;
                end
            end
            CPU_POLL: begin
                if (sr_reg[SR_READY]) cpu_state_next = CPU_WRITE;
            end
            CPU_WAIT_IRQ: begin
                if (irq) cpu_state_next = CPU_WRITE;
            end
            CPU_WRITE: begin
                write_en       = 1'b1;
                cpu_state_next = CPU_IDLE;
            end
            default: cpu_state_next = CPU_IDLE;
        endcase
    end

    // POC handshake block
    always_comb begin
        poc_state_next = poc_state_reg;
        send           = 1'b0;
        done           = 1'b0;
        case (poc_state_reg)
            POC_READY: begin
                if (write_en) poc_state_next = POC_SEND;
            end
            POC_SEND: begin
                send           = 1'b1;
                poc_state_next = POC_WAIT_PRN;
            end
            POC_WAIT_PRN: begin
                // While the strobe is still up the printer has not yet
                // consumed it, so its rdy=1 is stale and must be ignored.
                if (!tr_reg && prn_rdy) begin
                    done           = 1'b1;
                    poc_state_next = POC_READY;
                end
            end
            default: poc_state_next = POC_READY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cpu_state_reg <= CPU_IDLE;
            poc_state_reg <= POC_READY;
            func_q_reg    <= 1'b0;
            pending_reg   <= 1'b0;
            req_data_reg  <= 8'h00;
            mode_irq_reg  <= 1'b0;
            br_reg        <= 8'h00;
            sr_reg        <= 1'b1;
            tr_reg        <= 1'b0;
            pd_reg        <= 8'h00;
        end else begin
            cpu_state_reg <= cpu_state_next;
            poc_state_reg <= poc_state_next;
            func_q_reg    <= bus.func;

            // pending is always 1 in WRITE, so a request edge there is
            // dropped like any other edge while a request is pending.
            if (write_en) begin
                pending_reg <= 1'b0;
            end else if (req_edge && !pending_reg) begin
                pending_reg  <= 1'b1;
                req_data_reg <= bus.data_input;
            end

            if (dispatch) mode_irq_reg <= bus.Switch;
            if (write_en) br_reg <= req_data_reg;

            if (write_en) begin
                sr_reg[SR_READY] <= 1'b0;
            end else if (done) begin
                sr_reg[SR_READY] <= 1'b1;
            end

            tr_reg <= send;
            if (send) pd_reg <= br_reg;
        end
    end

    poc_printer #(
        .PRINT_DELAY (PRINT_DELAY)
    ) u_printer (
        .CLK  (CLK),
        .RST  (RST),
        .tr   (tr_reg),
        .pd   (pd_reg),
        .rdy  (prn_rdy),
        .data (prn_data)
    );

    assign bus.data = prn_data;
`ifdef POC_STATUS_EN
    assign bus.ready = sr_reg[SR_READY];
    assign bus.irq   = irq;
`endif

endmodule

// File: tb/tb_poc_top.sv
// Bench for poc_top: directed requests with hand-computed expected bytes
// and print cycles pushed into a scoreboard; a monitor pops and compares
// each time the printed byte changes. Status flags are checked directly.
module tb_poc_top;
    import poc_pkg::*;

    localparam int PD = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;

    poc_if bus ();

    poc_top #(.PRINT_DELAY(PD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    logic ready_obs, irq_obs;
`ifdef POC_STATUS_EN
    assign ready_obs = bus.ready;
    assign irq_obs   = bus.irq;
`else
    assign ready_obs = dut.sr_reg[SR_READY];
    assign irq_obs   = dut.irq;
`endif

    typedef struct {
        logic [7:0] b;
        int         at;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive a request edge; the print is expected 5 edges after the edge
    // that first samples func high (that edge brings cyc to k0).
    task automatic request(input logic [7:0] b, input bit expect_print, output int k0);
        @(negedge CLK);
        bus.data_input = b;
        bus.func       = 1'b1;
        k0 = cyc + 1;
        if (expect_print) sb.push_back('{b, k0 + 5});
        $display("req  byte=%02h mode=%0d cycle=%0d", b, bus.Switch, k0);
        @(negedge CLK);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    // Scoreboard monitor
    initial begin
        logic [7:0] last;
        exp_t e;
        last = 8'h00;
        forever begin
            @(negedge CLK);
            if (RST) begin
                last = bus.data;
            end else if (bus.data !== last) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_print: got %02h, required no print (cycle %0d)", bus.data, cyc);
                end else begin
                    e = sb.pop_front();
                    $display("prn  byte=%02h cycle=%0d (expected %02h at %0d)", bus.data, cyc, e.b, e.at);
                    check("print_data", 32'(bus.data), 32'(e.b));
                    check("print_cycle", cyc, e.at);
                end
                last = bus.data;
            end
        end
    end

    initial begin
        int k0;
        bus.func       = 1'b0;
        bus.data_input = 8'h00;
        bus.Switch     = 1'b0;

        // Reset held with func toggling
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            bus.func       = ~bus.func;
            bus.data_input = cyc[7:0];
            if (i % 10 == 9) begin
                check("rst_data", 32'(bus.data), 32'h00);
                check("rst_ready", 32'(ready_obs), 32'd1);
                check("rst_irq", 32'(irq_obs), 32'd0);
            end
        end
        bus.func = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        // Polling; func held high must give one request only
        bus.Switch = 1'b0;
        request(8'hF0, 1'b1, k0);
        wait_to(k0 + 3);  check("poll_ready_low_a", 32'(ready_obs), 32'd0);
        wait_to(k0 + 5);  check("poll_irq", 32'(irq_obs), 32'd0);
        wait_to(k0 + 13); check("poll_ready_low_b", 32'(ready_obs), 32'd0);
        wait_to(k0 + 14); check("poll_ready_back", 32'(ready_obs), 32'd1);
        wait_to(k0 + 40);
        bus.func       = 1'b0;
        bus.data_input = 8'h0F;
        wait_to(k0 + 140);
        request(8'h0F, 1'b1, k0);
        wait_to(k0 + 30);
        bus.func = 1'b0;

        // Interrupt
        bus.Switch = 1'b1;
        request(8'h6F, 1'b1, k0);
        wait_to(k0 + 2);  check("irq_before_dispatch", 32'(irq_obs), 32'd1);
        wait_to(k0 + 6);  check("irq_busy_a", 32'(irq_obs), 32'd0);
        wait_to(k0 + 12); check("irq_busy_b", 32'(irq_obs), 32'd0);
        wait_to(k0 + 14); check("irq_back", 32'(irq_obs), 32'd1);
        check("irq_ready_back", 32'(ready_obs), 32'd1);
        wait_to(k0 + 30);
        bus.func = 1'b0;

        // Mode return to polling
        bus.Switch = 1'b0;
        request(8'hF0, 1'b1, k0);
        wait_to(k0 + 2);  check("ret_irq_a", 32'(irq_obs), 32'd0);
        wait_to(k0 + 14); check("ret_irq_b", 32'(irq_obs), 32'd0);
        wait_to(k0 + 20);
        bus.func = 1'b0;
        wait_to(k0 + 200);
        request(8'h0F, 1'b1, k0);
        wait_to(k0 + 14); check("ret_irq_c", 32'(irq_obs), 32'd0);
        wait_to(k0 + 30);
        bus.func = 1'b0;

        // Busy overlap: second edge 3 cycles after the first is dropped
        request(8'hAA, 1'b1, k0);
        bus.func = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        bus.func       = 1'b1;
        bus.data_input = 8'h55;
        $display("req  byte=55 (overlap, expect ignored) cycle=%0d", cyc + 1);
        wait_to(k0 + 60);
        check("overlap_data", 32'(bus.data), 32'hAA);
        bus.func = 1'b0;
        repeat (5) @(negedge CLK);

        // Reset while the printer is busy
        request(8'h3C, 1'b1, k0);
        wait_to(k0 + 8);
        RST      = 1'b1;
        bus.func = 1'b0;
        @(negedge CLK);
        check("midrst_data", 32'(bus.data), 32'h00);
        check("midrst_ready", 32'(ready_obs), 32'd1);
        check("midrst_irq", 32'(irq_obs), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        request(8'h81, 1'b1, k0);
        wait_to(k0 + 30);
        bus.func = 1'b0;
        check("final_data", 32'(bus.data), 32'h81);

        repeat (20) @(negedge CLK);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
